// File: rtl/spi_master_burst.sv
// Purpose: multi-slave SPI master with per-slave mode/bit-order/CS-polarity/divider and CS-held multi-word bursts.
// Latency: CS/SCLK/MOSI change the cycle after accept; rx word pulses 2+2*DATA_WIDTH*div cycles after accept.
// Backpressure: o_tx_ready only in IDLE or between burst words (HOLD, waits indefinitely); low while shifting/gapping.
module spi_master_burst #(
    parameter int DATA_WIDTH             = 8,
    parameter int NUM_SLAVES             = 8,
    parameter int DIV_W                  = 8,
    parameter int DEFAULT_HALF_BIT_CLKS  = 2,
    parameter int SPI_CS_INACTIVE_CLOCKS = 4,
    localparam int SS_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_config_slave,
    input  logic [SS_W-1:0]       i_slave_select,
    input  logic [3:0]            i_config_data,
    input  logic [DIV_W-1:0]      i_config_div,
    input  logic                  i_tx_data_valid,
    input  logic [DATA_WIDTH-1:0] i_tx_data_word,
    input  logic                  i_tx_last,
    output logic                  o_tx_ready,
    output logic                  o_rx_data_valid,
    output logic [DATA_WIDTH-1:0] o_rx_data_word,
    output logic                  o_busy,
    output logic                  o_spi_sclk,
    output logic [NUM_SLAVES-1:0] o_spi_cs,
    output logic                  o_spi_mosi,
    input  logic                  i_spi_miso
);
    localparam int CPOL  = 3;
    localparam int CPHA  = 2;
    localparam int LSBF  = 1;
    localparam int CSPOL = 0;
    localparam int EC_W  = $clog2(2*DATA_WIDTH + 1);
    localparam int GAP_W = (SPI_CS_INACTIVE_CLOCKS > 1) ? $clog2(SPI_CS_INACTIVE_CLOCKS) : 1;
    localparam logic [EC_W-1:0]  EDGE_LAST = EC_W'(2*DATA_WIDTH);
    localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(SPI_CS_INACTIVE_CLOCKS - 1);
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_HALF_BIT_CLKS);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_HOLD, S_TRAIL, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cfg_q [NUM_SLAVES];
    logic [3:0]            cfg_d [NUM_SLAVES];
    logic [DIV_W-1:0]      div_q [NUM_SLAVES];
    logic [DIV_W-1:0]      div_d [NUM_SLAVES];
    logic [3:0]            cur_cfg_q, cur_cfg_d;
    logic [DIV_W-1:0]      cur_div_q, cur_div_d;
    logic [SS_W-1:0]       cur_slv_q, cur_slv_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [EC_W-1:0]       edge_q, edge_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0] cs_q, cs_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  rx_vld_q, rx_vld_d;
    logic [DATA_WIDTH-1:0] rx_word_q, rx_word_d;

    logic                  accept, load, leading, cs_on;
    logic [DIV_W-1:0]      div_m1;
    logic [DATA_WIDTH-1:0] tx_next;

    // Next-state: config writes, burst latching, SCLK edge generation, shifting/sampling and registered outputs.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        div_d     = div_q;
        cur_cfg_d = cur_cfg_q;
        cur_div_d = cur_div_q;
        cur_slv_d = cur_slv_q;
        last_d    = last_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        gap_d     = gap_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        rx_vld_d  = 1'b0;
        rx_word_d = rx_word_q;
        load      = 1'b0;
        leading   = ~edge_q[0];
        accept    = i_tx_data_valid && ready_q;
        div_m1    = cur_div_q - DIV_ONE;
        tx_next   = cur_cfg_q[LSBF] ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]} : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};

        // Out-of-range indices match no slot, so such writes fall away.
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i_config_slave && int'(i_slave_select) == i) begin
                cfg_d[i] = i_config_data;
                div_d[i] = i_config_div;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Latch from cfg_q so a same-cycle write only affects later bursts.
                    cur_cfg_d = 4'b0000;
                    cur_div_d = (DIV_RST == '0) ? DIV_ONE : DIV_RST;
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        if (int'(i_slave_select) == i) begin
                            cur_cfg_d = cfg_q[i];
                            cur_div_d = (div_q[i] == '0) ? DIV_ONE : div_q[i];
                        end
                    end
                    cur_slv_d = i_slave_select;
                    sclk_d    = cur_cfg_d[CPOL];
                    load      = 1'b1;
                    state_d   = S_LEAD;
                end
            end
            S_LEAD, S_SHIFT: begin
                cnt_d = (cnt_q == div_m1) ? '0 : cnt_q + 1'b1;
                if (edge_q != EDGE_LAST) begin
                    if (cnt_q == div_m1) begin
                        edge_d  = edge_q + 1'b1;
                        sclk_d  = ~sclk_q;
                        state_d = S_SHIFT;
                        if (leading != cur_cfg_q[CPHA]) begin
                            rx_sh_d = cur_cfg_q[LSBF] ? {i_spi_miso, rx_sh_q[DATA_WIDTH-1:1]}
                                                      : {rx_sh_q[DATA_WIDTH-2:0], i_spi_miso};
                        end else if (cur_cfg_q[CPHA]) begin
                            mosi_d  = cur_cfg_q[LSBF] ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
                            tx_sh_d = tx_next;
                        end else begin
                            mosi_d  = cur_cfg_q[LSBF] ? tx_next[0] : tx_next[DATA_WIDTH-1];
                            tx_sh_d = tx_next;
                        end
                    end
                end else begin
                    // Word complete: deliver it, then hold SCLK idle for one half-bit before HOLD/TRAIL.
                    if (cnt_q == '0) begin
                        rx_vld_d  = 1'b1;
                        rx_word_d = rx_sh_q;
                    end
                    if (cnt_q == div_m1) begin
                        state_d = last_q ? S_TRAIL : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_TRAIL: begin
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_END) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            tx_sh_d = i_tx_data_word;
            last_d  = i_tx_last;
            cnt_d   = '0;
            edge_d  = '0;
            if (!cur_cfg_d[CPHA]) begin
                mosi_d = cur_cfg_d[LSBF] ? i_tx_data_word[0] : i_tx_data_word[DATA_WIDTH-1];
            end
        end

        cs_on = (state_d == S_LEAD) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cs_d[i] = (cs_on && int'(cur_slv_d) == i) ? cur_cfg_d[CSPOL] : ~cfg_d[i][CSPOL];
        end
        ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; synchronous reset aborts any burst and restores default slave configs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < NUM_SLAVES; i++) begin
                cfg_q[i] <= 4'b0000;
                div_q[i] <= DIV_RST;
            end
            cur_cfg_q <= 4'b0000;
            cur_div_q <= DIV_ONE;
            cur_slv_q <= '0;
            last_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            cnt_q     <= '0;
            edge_q    <= '0;
            gap_q     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= '1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            rx_vld_q  <= 1'b0;
            rx_word_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            div_q     <= div_d;
            cur_cfg_q <= cur_cfg_d;
            cur_div_q <= cur_div_d;
            cur_slv_q <= cur_slv_d;
            last_q    <= last_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            gap_q     <= gap_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            rx_vld_q  <= rx_vld_d;
            rx_word_q <= rx_word_d;
        end
    end

    assign o_tx_ready      = ready_q;
    assign o_rx_data_valid = rx_vld_q;
    assign o_rx_data_word  = rx_word_q;
    assign o_busy          = busy_q;
    assign o_spi_sclk      = sclk_q;
    assign o_spi_cs        = cs_q;
    assign o_spi_mosi      = mosi_q;
endmodule

// File: tb/tb_spi_master_burst.sv
// Bench for spi_master_burst: 8-bit instance with loopback (optionally inverted) MISO, plus a 16-bit instance.
// Expected words, timings and MOSI bit sequences come from a per-slave config model and the frame timing rules.
// Inputs driven on the falling clock edge, outputs observed on the falling edge.
module tb_spi_master_burst;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] sel = '0;
    logic [3:0] cfg_dat = '0;
    logic [7:0] cfg_div = '0;
    logic       tx_vld = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_word = '0;
    logic       tx_rdy, rx_vld, busy, sclk, mosi, miso;
    logic [7:0] rx_word, cs;
    bit         inv = 1'b0;
    assign miso = inv ? ~mosi : mosi;

    spi_master_burst dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_config_slave(cfg_wr), .i_slave_select(sel),
        .i_config_data(cfg_dat), .i_config_div(cfg_div), .i_tx_data_valid(tx_vld),
        .i_tx_data_word(tx_word), .i_tx_last(tx_last), .o_tx_ready(tx_rdy),
        .o_rx_data_valid(rx_vld), .o_rx_data_word(rx_word), .o_busy(busy),
        .o_spi_sclk(sclk), .o_spi_cs(cs), .o_spi_mosi(mosi), .i_spi_miso(miso));

    logic        w_wr = 1'b0, w_vld = 1'b0, w_last = 1'b1;
    logic [2:0]  w_sel = '0;
    logic [3:0]  w_dat = '0;
    logic [7:0]  w_div = '0;
    logic [15:0] w_word = '0;
    logic        w_rdy, w_rxv, w_busy, w_sclk, w_mosi;
    logic [15:0] w_rxw;
    logic [7:0]  w_cs;

    spi_master_burst #(.DATA_WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_config_slave(w_wr), .i_slave_select(w_sel),
        .i_config_data(w_dat), .i_config_div(w_div), .i_tx_data_valid(w_vld),
        .i_tx_data_word(w_word), .i_tx_last(w_last), .o_tx_ready(w_rdy),
        .o_rx_data_valid(w_rxv), .o_rx_data_word(w_rxw), .o_busy(w_busy),
        .o_spi_sclk(w_sclk), .o_spi_cs(w_cs), .o_spi_mosi(w_mosi), .i_spi_miso(w_mosi));

    // Reference model: per-slave config as last written, plus the config captured by the open burst.
    logic [3:0] m_cfg [8];
    int         m_div [8];
    logic [3:0] b_cfg;
    int         b_div, b_slv;
    bit         in_burst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cfg[i] = 4'b0000;
            m_div[i] = 2;
        end
        in_burst = 1'b0;
    endtask

    function automatic logic [7:0] cs_pat(input bit active);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = (active && i == b_slv) ? b_cfg[0] : ~m_cfg[i][0];
        return p;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic cfg_write(input int s, input logic [3:0] d, input int dv);
        cfg_wr = 1'b1; sel = 3'(s); cfg_dat = d; cfg_div = 8'(dv);
        @(negedge clk);
        cfg_wr = 1'b0;
        m_cfg[s] = d;
        m_div[s] = (dv == 0) ? 1 : dv;
    endtask

    // One word of a burst: offer, wait for accept, follow the frame and the following HOLD or gap.
    task automatic xfer(input int s, input logic [7:0] w, input bit last, input bit inv_i);
        int T, n, edges, e1, rxc, cs_err, busy_err, idle_n;
        logic prev;
        logic [7:0] got_seq, exp_pat, rxw, exp_rx;
        bit got_rx, odd;
        inv = inv_i; sel = 3'(s); tx_word = w; tx_last = last; tx_vld = 1'b1;
        n = 0;
        while (!tx_rdy && n < 500) begin @(negedge clk); n++; end
        check("accept_wait", n < 500, 1);
        if (!in_burst) begin
            b_slv = s; b_cfg = m_cfg[s]; b_div = m_div[s]; in_burst = 1'b1;
        end
        T = cyc;
        @(negedge clk);
        tx_vld = 1'b0;
        exp_pat = cs_pat(1'b1);
        check("cs_assert", cs, exp_pat);
        check("sclk_start", sclk, b_cfg[3]);
        if (!b_cfg[2]) check("mosi_first", mosi, b_cfg[1] ? w[0] : w[7]);
        prev = sclk; edges = 0; e1 = -1; got_rx = 0; got_seq = '0; cs_err = 0; busy_err = 0; rxc = -1; rxw = '0;
        for (int c = 0; c < 200 && !got_rx; c++) begin
            @(negedge clk);
            if (sclk !== prev) begin
                edges++; prev = sclk;
                if (edges == 1) e1 = cyc;
                odd = (edges % 2) == 1;
                if (odd != b_cfg[2]) got_seq = {got_seq[6:0], mosi};
            end
            if (rx_vld === 1'b1) begin
                got_rx = 1; rxc = cyc; rxw = rx_word;
            end else begin
                if (cs !== exp_pat) cs_err++;
                if (busy !== 1'b1) busy_err++;
            end
        end
        exp_rx = inv_i ? ~w : w;
        check("rx_seen", got_rx, 1);
        check("rx_word", rxw, exp_rx);
        check("rx_time", rxc, T + 2 + 16*b_div);
        check("sclk_edges", edges, 16);
        check("edge1_time", e1, T + 1 + b_div);
        check("mosi_order", got_seq, b_cfg[1] ? rev8(w) : w);
        check("cs_frame", cs_err, 0);
        check("busy_frame", busy_err, 0);
        n = 0; idle_n = 0;
        while (!tx_rdy && n < 100) begin
            if (cs === cs_pat(1'b0)) idle_n++;
            @(negedge clk); n++;
        end
        check("ready_wait", n < 100, 1);
        if (last) begin
            in_burst = 1'b0;
            check("gap_len", idle_n >= 4, 1);
            check("idle_cs", cs, cs_pat(1'b0));
            check("idle_busy", busy, 0);
            check("idle_sclk", sclk, b_cfg[3]);
        end else begin
            check("hold_time", cyc, T + 1 + 17*b_div);
            check("hold_cs", cs, exp_pat);
            check("hold_busy", busy, 1);
        end
    endtask

    initial begin
        int n, edges, rxn, T, len, s;
        logic prev;
        bit got;
        model_reset();

        // Reset held with a word on offer: pins idle, nothing accepted.
        tx_vld = 1'b1; tx_word = 8'hFF; tx_last = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 8'hFF);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rdy", tx_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_rxv", rx_vld, 0);
        check("rst_rxw", rx_word, 0);
        rst_n = 1'b1; tx_vld = 1'b0;
        @(negedge clk);
        check("rel_rdy", tx_rdy, 1);
        check("rel_cs", cs, 8'hFF);
        check("rel_busy", busy, 0);

        // SPI modes 0..3 on slaves 0..3.
        for (int i = 0; i < 4; i++) begin
            cfg_write(i, 4'(i << 2), 2);
            xfer(i, 8'hA5, 1'b1, 1'b0);
        end

        // LSB-first with active-high CS.
        cfg_write(0, 4'b0011, 2);
        xfer(0, 8'h01, 1'b1, 1'b0);
        check("cs0_idle_low", cs[0], 0);

        // Three-word burst; later words carry a different select that must be ignored.
        xfer(2, 8'h11, 1'b0, 1'b0);
        xfer(5, 8'h22, 1'b0, 1'b1);
        xfer(1, 8'h33, 1'b1, 1'b0);

        // Reset after the fifth SCLK edge of a mode-3 frame on slave 3.
        sel = 3'd3; tx_word = 8'h5A; tx_last = 1'b1; tx_vld = 1'b1; inv = 1'b0;
        n = 0;
        while (!tx_rdy && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_vld = 1'b0;
        prev = sclk; edges = 0; n = 0;
        while (edges < 5 && n < 100) begin
            @(negedge clk); n++;
            if (sclk !== prev) begin edges++; prev = sclk; end
        end
        check("abort_edges", edges, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cs", cs, 8'hFF);
        check("abort_sclk", sclk, 0);
        check("abort_rdy", tx_rdy, 0);
        rst_n = 1'b1;
        model_reset();
        rxn = 0;
        repeat (40) begin
            if (rx_vld === 1'b1) rxn++;
            @(negedge clk);
        end
        check("abort_no_rx", rxn, 0);
        check("abort_busy", busy, 0);
        xfer(3, 8'hC3, 1'b1, 1'b0);

        // Randomized bursts: random slave, config, divider (0 included), length, payload and MISO inversion.
        for (int b = 0; b < 10; b++) begin
            s = $urandom_range(0, 7);
            cfg_write(s, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
                xfer((j == 0) ? s : $urandom_range(0, 7), 8'($urandom), j == len - 1, 1'($urandom_range(0, 1)));
            end
        end

        // 16-bit words, divider 0 running as 1, config write coinciding with accept.
        w_wr = 1'b1; w_sel = 3'd0; w_dat = 4'b0000; w_div = 8'd0;
        @(negedge clk);
        w_wr = 1'b0;
        n = 0;
        while (!w_rdy && n < 100) begin @(negedge clk); n++; end
        w_wr = 1'b1; w_dat = 4'b1001; w_div = 8'd3; w_vld = 1'b1; w_word = 16'hBEEF;
        check("w16_rdy", w_rdy, 1);
        T = cyc;
        @(negedge clk);
        w_wr = 1'b0; w_vld = 1'b0;
        check("w16_sclk_old", w_sclk, 0);
        check("w16_cs_old", w_cs[0], 0);
        got = 0; n = 0;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            if (w_rxv === 1'b1) begin
                got = 1;
                check("w16_rx", w_rxw, 16'hBEEF);
                check("w16_time", cyc, T + 2 + 32);
            end
        end
        check("w16_rx_seen", got, 1);
        n = 0;
        while (!w_rdy && n < 100) begin @(negedge clk); n++; end
        check("w16_idle_cs", w_cs[0], 0);
        w_vld = 1'b1; w_word = 16'h1234;
        T = cyc;
        @(negedge clk);
        w_vld = 1'b0;
        check("w16_sclk_new", w_sclk, 1);
        check("w16_cs_new", w_cs[0], 1);
        got = 0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk); n++;
            if (w_rxv === 1'b1) begin
                got = 1;
                check("w16_rx2", w_rxw, 16'h1234);
                check("w16_time2", cyc, T + 2 + 32*3);
            end
        end
        check("w16_rx2_seen", got, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
